// File: rtl/sram_pkg.sv
// Shared types and helpers for the sram_bank data RAM peripheral.
`default_nettype none

package sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int unsigned WAIT_CNT_W = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_array.sv
// Word storage with byte-masked write and registered (synchronous) read; no reset.
`default_nettype none

module sram_array
  import sram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [DATA_W/8-1:0]      wstrb,
  input  logic [clog2(DEPTH)-1:0]  index,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  localparam int BYTES = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wstrb[i]) begin
          r_mem[index][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    rdata <= r_mem[index];
  end

endmodule

`default_nettype wire

// File: rtl/sram_bank.sv
// Data RAM peripheral: address decode, request/response FSM, wait-state counter
// and response registers in front of an sram_array.
`default_nettype none

module sram_bank
  import sram_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int LSB_W = clog2(BYTES);
  localparam int IDX_W = clog2(DEPTH);
  localparam logic [ADDR_W:0]         c_SPAN     = (ADDR_W+1)'(DEPTH * BYTES);
  localparam logic [ADDR_W-1:0]       c_LSB_MASK = ADDR_W'(BYTES - 1);
  localparam logic [WAIT_CNT_W-1:0]   c_WAIT     = WAIT_CNT_W'(WAIT_CYCLES);

  state_t                r_state;
  state_t                w_next;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic                  r_err;
  logic                  r_rd_ok;
  logic [IDX_W-1:0]      r_index;

  logic [ADDR_W-1:0]     w_off;
  logic                  w_in_range;
  logic                  w_aligned;
  logic                  w_err;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_accept;
  logic                  w_rsp_hs;
  logic                  w_arr_we;
  logic [IDX_W-1:0]      w_arr_index;
  logic [DATA_W-1:0]     w_arr_rdata;

  assign w_off      = req_addr - BASE_ADDR;
  assign w_in_range = (req_addr >= BASE_ADDR) && ({1'b0, w_off} < c_SPAN);
  assign w_aligned  = (w_off & c_LSB_MASK) == '0;
  assign w_err      = !(w_in_range && w_aligned);
  assign w_idx      = IDX_W'(w_off >> LSB_W);

  assign req_ready = (r_state == ST_IDLE) && !rst;
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_err   = r_err;
  assign w_accept  = req_valid && req_ready;
  assign w_rsp_hs  = rsp_valid && rsp_ready;
  assign w_arr_we  = w_accept && req_we && !w_err;

  // Holding the captured index keeps the array's registered read output
  // stable for the whole transaction, so no separate read-data register is needed.
  assign w_arr_index = (r_state == ST_IDLE) ? w_idx : r_index;
  assign rsp_rdata   = r_rd_ok ? w_arr_rdata : '0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (r_cnt <= 4'd1) w_next = ST_RESP;
      ST_RESP: if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_rd_ok <= 1'b0;
      r_index <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= c_WAIT;
        r_err   <= w_err;
        r_rd_ok <= !req_we && !w_err;
        r_index <= w_idx;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 1'b1;
      end else if (w_rsp_hs) begin
        r_err   <= 1'b0;
        r_rd_ok <= 1'b0;
      end
    end
  end

  sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (w_arr_we),
    .wstrb (req_wstrb),
    .index (w_arr_index),
    .wdata (req_wdata),
    .rdata (w_arr_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_sram_bank.sv
// Bench for sram_bank: two instances (no wait states at base 0, three wait
// states at base 0x8000_0000) checked against a word-array reference model.
`default_nettype none

module tb_sram_bank;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wstrb [2];
  logic [31:0] rsp_rdata [2];

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl [2][1024];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_bank #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(1024),
    .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  sram_bank #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(1024),
    .BASE_ADDR(32'h8000_0000), .WAIT_CYCLES(3)
  ) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0000_0000 : 32'h8000_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance d, rsp_ready held low for `hold` cycles.
  task automatic txn(input int d, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] st, input int hold,
                     output logic [31:0] got_rd, output logic got_err);
    longint off;
    logic   ok;
    int     idx, lat, guard;
    logic [31:0] exp_rd;

    off = longint'(addr) - longint'(base_of(d));
    ok  = (off >= 0) && (off < 4096) && (off % 4 == 0);
    idx = ok ? int'(off / 4) : 0;
    exp_rd = (!we && ok) ? mdl[d][idx] : 32'h0;

    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
    req_wdata[d] = wd;   req_wstrb[d] = st;
    guard = 0;
    while (!req_ready[d] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("req_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    if (ok && we) begin
      for (int i = 0; i < 4; i++)
        if (st[i]) mdl[d][idx][8*i +: 8] = wd[8*i +: 8];
    end
    #1;
    // Scramble request inputs: they must have been captured at acceptance.
    req_valid[d] = 1'b0; req_we[d] = $urandom_range(0, 1) == 1;
    req_addr[d] = $urandom; req_wdata[d] = $urandom; req_wstrb[d] = 4'($urandom);

    @(negedge clk);
    check("req_ready_busy", {31'd0, req_ready[d]}, 32'd0);
    lat = 1;
    while (!rsp_valid[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 1 + wait_of(d));
    got_rd  = rsp_rdata[d];
    got_err = rsp_err[d];
    check("rsp_rdata", got_rd, exp_rd);
    check("rsp_err", {31'd0, got_err}, {31'd0, !ok});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, rsp_valid[d]}, 32'd1);
      check("hold_rdata", rsp_rdata[d], exp_rd);
      check("hold_err", {31'd0, rsp_err[d]}, {31'd0, !ok});
      check("hold_ready", {31'd0, req_ready[d]}, 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    check("post_valid", {31'd0, rsp_valid[d]}, 32'd0);
    check("post_rdata", rsp_rdata[d], 32'd0);
    check("post_err", {31'd0, rsp_err[d]}, 32'd0);
    check("post_ready", {31'd0, req_ready[d]}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    int          guard;

    rst = 1'b1;
    req_valid = '0; req_we = '0; rsp_ready = '0;
    for (int d = 0; d < 2; d++) begin
      req_addr[d] = '0; req_wdata[d] = '0; req_wstrb[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_valid", {31'd0, rsp_valid[d]}, 32'd0);
      check("rst_rdata", rsp_rdata[d], 32'd0);
      check("rst_err", {31'd0, rsp_err[d]}, 32'd0);
      check("rst_ready", {31'd0, req_ready[d]}, 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", {30'd0, req_ready}, 32'd3);

    // Full write then read-back, zero wait states.
    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
    check("rd_deadbeef", rd, 32'hDEAD_BEEF);

    // Byte-lane merge.
    txn(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 0, rd, er);
    txn(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 1, rd, er);
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er);
    check("rd_merge", rd, 32'h11BB_33DD);

    // Zero strobe is a no-op, errors leave the array alone.
    txn(0, 1'b1, 32'h0, 32'h5A5A_0F0F, 4'hF, 0, rd, er);
    txn(0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'h0, 0, rd, er);
    txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, rd, er);
    check("oor_err", {31'd0, er}, 32'd1);
    txn(0, 1'b1, 32'h2, 32'hFFFF_FFFF, 4'hF, 0, rd, er);
    check("misalign_err", {31'd0, er}, 32'd1);
    txn(0, 1'b0, 32'h2, 32'h0, 4'h0, 0, rd, er);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er);
    check("rd_zero_word", rd, 32'h5A5A_0F0F);

    // Wait states, back-pressure, non-zero base.
    txn(1, 1'b1, 32'h8000_0004, 32'hCAFE_F00D, 4'hF, 0, rd, er);
    txn(1, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 5, rd, er);
    check("base_word1", rd, 32'hCAFE_F00D);
    txn(1, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, rd, er);
    check("below_base_err", {31'd0, er}, 32'd1);

    // Reset while a response is pending.
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!rsp_valid[0] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("pre_rst_valid", {31'd0, rsp_valid[0]}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_drop_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("rst_drop_ready", {31'd0, req_ready[0]}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_rel_ready", {31'd0, req_ready[0]}, 32'd1);
    check("rst_no_rsp", {31'd0, rsp_valid[0]}, 32'd0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
    check("survive_rst", rd, 32'hDEAD_BEEF);

    // Randomized traffic over an initialised 8-word window per instance.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 8; w++)
        txn(d, 1'b1, base_of(d) + 32'h40 + 32'(4 * w), $urandom, 4'hF, 0, rd, er);
      for (int n = 0; n < 24; n++) begin
        case ($urandom_range(0, 7))
          0:       a = base_of(d) + 32'h1000 + 32'(4 * $urandom_range(0, 3));
          1:       a = base_of(d) + 32'h40 + 32'($urandom_range(1, 3));
          2:       a = base_of(d) - 32'h4;
          default: a = base_of(d) + 32'h40 + 32'(4 * $urandom_range(0, 7));
        endcase
        txn(d, $urandom_range(0, 1) == 1, a, $urandom, 4'($urandom),
            $urandom_range(0, 2), rd, er);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
